hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Sequences the 5-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM) and the PC.
- Detects load-use hazards and inserts bubbles into ID/EX.
- Flushes wrong-path instructions when a branch resolves taken in MEM.
- Freezes the whole pipe while data memory is busy, and keeps saturating stall/flush event counters for debug.

Parameters:
- REG_W, 5: register-index width.
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard (1..3).
- CNT_W, 16: event counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  REG_W  ID-stage source register (instr bits 25:21).
- id_rt  in  REG_W  ID-stage source register (instr bits 20:16).
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- idex_rt  in  REG_W  bits20_16 latched in ID/EX.
- idex_mem_read  in  1  MemtoRead latched in ID/EX.
- exmem_branch  in  1  Branch latched in EX/MEM.
- exmem_zero  in  1  ALU zero latched in EX/MEM.
- dmem_busy  in  1  data memory cannot complete this cycle.
- pc_write  out  1  PC load enable.
- pc_src  out  1  1 = load branch target.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID load NOP.
- idex_write  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX load zero controls (bubble).
- exmem_write  out  1  EX/MEM load enable.
- exmem_flush  out  1  EX/MEM load zero controls.
- stall_cnt  out  CNT_W  bubbles inserted, saturating.
- flush_cnt  out  CNT_W  taken-branch flushes, saturating.

Behaviour:
- Timing: state and counters are registered. All enable/flush outputs are combinational from current state plus inputs, with zero latency, so pipeline registers sample them on the same edge.
- Flush precedence: flush wins over write in the downstream register.
- Reset, while rst=1:
  - state=RUN, stall counter=0, stall_cnt=0, flush_cnt=0.
  - pc_write=0, pc_src=0, ifid_write=0, all *_flush=1, idex_write=1, exmem_write=1.
  - Reset mid-stall or mid-wait aborts immediately; no pending bubble survives.
- Derived signals:
  - hazard = idex_mem_read & (idex_rt!=0) & ((id_uses_rs & id_rs==idex_rt) | (id_uses_rt & id_rt==idex_rt)).
  - taken = exmem_branch & exmem_zero.
- States: RUN, STALL, MEM_WAIT.
- Priority each cycle: dmem_busy > taken > hazard/STALL > normal.
- dmem_busy=1, any state:
  - All write enables 0, all flushes 0, pc_src=0.
  - Next state MEM_WAIT; the stall counter is held.
  - No counters increment.
- MEM_WAIT with dmem_busy=0:
  - Behaves as RUN or STALL, according to a saved return flag.
  - taken/hazard are re-evaluated; a branch frozen in EX/MEM is handled now.
- taken (not busy):
  - pc_src=1, pc_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1.
  - A pending stall is cancelled (counter=0, next RUN); flush_cnt+1.
- RUN with hazard (not busy, not taken):
  - pc_write=0, ifid_write=0, idex_flush=1; stall_cnt+1.
  - If LOAD_STALL_CYCLES>1: next state STALL with counter=LOAD_STALL_CYCLES-2. Otherwise stay RUN.
- STALL (not busy, not taken):
  - Same outputs as the hazard case; stall_cnt+1.
  - When counter==0, next state RUN; else decrement the counter.
- Normal: all writes 1, all flushes 0, pc_src=0.
- Register 0 never causes a hazard.
- Counters saturate at all-ones; no wrap.

Decomposition:
- Shared package `pipe_ctrl_pkg`:
  - State enum (RUN, STALL, MEM_WAIT).
  - Register 0 constant `REG_ZERO`.
  - NOP/bubble control constant shared with the ID/EX register.
- One sub-module, `sat_counter`, parameterized width with increment enable and async reset; instantiated twice.

Test Plan:
- Reset asserted mid-STALL (LOAD_STALL_CYCLES=3), then released → next cycle pc_write=1, no flushes, stall_cnt=0.
- idex_mem_read=1, idex_rt=8, id_rs=8, id_uses_rs=1 → exactly one cycle pc_write=0, ifid_write=0, idex_flush=1, then normal; stall_cnt=1. Repeat with idex_rt=0 → no stall.
- LOAD_STALL_CYCLES=3, hazard on rt=9 → three consecutive bubble cycles, then RUN; stall_cnt=3.
- taken (exmem_branch=1, exmem_zero=1) on the second cycle of a 3-cycle stall → pc_src=1, three flushes that cycle, stall cancelled, flush_cnt=1, stall_cnt=2.
- dmem_busy high 4 cycles during a hazard → all enables 0 for 4 cycles, counters frozen; on release the bubble is inserted, stall_cnt=1.
- CNT_W=4, 20 single-cycle hazards → stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and control bundles for the pipeline hazard controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, STALL, MEM_WAIT} state_e;
  localparam int REG_ZERO = 0;
  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic exmem_flush;
  } ctl_t;
  // ID/EX loads this all-zero control word when a bubble is inserted
  localparam logic [8:0] IDEX_NOP = 9'h000;
  localparam ctl_t CTL_NORMAL = 8'b1010_1010;
  localparam ctl_t CTL_BUBBLE = 8'b0000_1110;
  localparam ctl_t CTL_TAKEN  = 8'b1111_1111;
  localparam ctl_t CTL_FREEZE = 8'b0000_0000;
  localparam ctl_t CTL_RESET  = 8'b0001_1111;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with increment enable that sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stalls, taken-branch flushes and memory freezes for a 5-stage pipe.
module hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W             = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             idex_mem_read,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES > 1 ? LOAD_STALL_CYCLES - 2 : 0);
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic ret_q, ret_d;
  logic hazard, taken, eff_stall, stall_inc, flush_inc;
  ctl_t ctl;
  assign hazard = idex_mem_read && (idex_rt != REG_W'(REG_ZERO)) &&
                  ((id_uses_rs && id_rs == idex_rt) || (id_uses_rt && id_rt == idex_rt));
  assign taken = exmem_branch && exmem_zero;
  // a freeze remembers whether it interrupted a stall so the bubbles resume afterwards
  assign eff_stall = state_q == STALL || (state_q == MEM_WAIT && ret_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
    end
  end
  always_comb begin
    state_d = RUN;
    cnt_d   = cnt_q;
    ret_d   = 1'b0;
    if (dmem_busy) begin
      state_d = MEM_WAIT;
      ret_d   = eff_stall;
    end else if (taken) begin
      cnt_d = '0;
    end else if (eff_stall) begin
      state_d = cnt_q == '0 ? RUN : STALL;
      cnt_d   = cnt_q == '0 ? '0 : cnt_q - 2'd1;
    end else if (hazard) begin
      state_d = LOAD_STALL_CYCLES > 1 ? STALL : RUN;
      cnt_d   = STALL_INIT;
    end
  end
  always_comb begin
    ctl = rst ? CTL_RESET : dmem_busy ? CTL_FREEZE : taken ? CTL_TAKEN :
          (eff_stall || hazard) ? CTL_BUBBLE : CTL_NORMAL;
    stall_inc = !rst && !dmem_busy && !taken && (eff_stall || hazard);
    flush_inc = !rst && !dmem_busy && taken;
  end
  assign {pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_flush} = ctl;
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall_inc), .cnt(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush_inc), .cnt(flush_cnt));
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: vector table plus hand sequences on three parameterisations of hazard_controller.
module tb_hazard_controller;
  localparam logic [7:0] NRM = 8'b1010_1010;
  localparam logic [7:0] BUB = 8'b0000_1110;
  localparam logic [7:0] TKN = 8'b1111_1111;
  localparam logic [7:0] FRZ = 8'b0000_0000;
  localparam logic [7:0] RST = 8'b0001_1111;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
  logic id_uses_rs = 1'b0, id_uses_rt = 1'b0, idex_mem_read = 1'b0;
  logic exmem_branch = 1'b0, exmem_zero = 1'b0, dmem_busy = 1'b0;
  logic [7:0] ctl_w [3];
  logic [15:0] sc_w [3], fc_w [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = g == 2 ? 4 : 16;
    logic [CW-1:0] s, f;
    hazard_controller #(.REG_W(5), .LOAD_STALL_CYCLES(g == 1 ? 3 : 1), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
      .id_uses_rt(id_uses_rt), .idex_rt(idex_rt), .idex_mem_read(idex_mem_read),
      .exmem_branch(exmem_branch), .exmem_zero(exmem_zero), .dmem_busy(dmem_busy),
      .pc_write(ctl_w[g][7]), .pc_src(ctl_w[g][6]), .ifid_write(ctl_w[g][5]),
      .ifid_flush(ctl_w[g][4]), .idex_write(ctl_w[g][3]), .idex_flush(ctl_w[g][2]),
      .exmem_write(ctl_w[g][1]), .exmem_flush(ctl_w[g][0]), .stall_cnt(s), .flush_cnt(f));
    assign sc_w[g] = 16'(s);
    assign fc_w[g] = 16'(f);
  end
  typedef struct {
    int sel;
    logic rst;
    logic [4:0] rs, rt;
    logic urs, urt;
    logic [4:0] xrt;
    logic mr, br, z, busy;
    logic [7:0] ctl;
    logic chk;
    logic [15:0] sc, fc;
  } vec_t;
  vec_t tbl[$];
  vec_t exp_q[$];
  int passed = 0, total = 0, step = 0;
  function automatic vec_t mk(int s, logic r, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic [4:0] xrt, logic mr, logic br, logic z, logic busy,
                              logic [7:0] c, logic k, logic [15:0] sc, logic [15:0] fc);
    vec_t v;
    v.sel = s; v.rst = r; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.xrt = xrt;
    v.mr = mr; v.br = br; v.z = z; v.busy = busy; v.ctl = c; v.chk = k; v.sc = sc; v.fc = fc;
    return v;
  endfunction
  function automatic vec_t idle(int s, logic [7:0] c, logic k = 0, logic [15:0] sc = 0, logic [15:0] fc = 0);
    return mk(s, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c, k, sc, fc);
  endfunction
  function automatic vec_t hz(int s, logic [7:0] c);
    return mk(s, 0, 0, 9, 0, 1, 9, 1, 0, 0, 0, c, 0, 0, 0);
  endfunction
  function automatic vec_t rstv(int s);
    return mk(s, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 1, 0, 0);
  endfunction
  task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
  endtask
  task automatic cyc(input vec_t v);
    vec_t e;
    rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    idex_rt = v.xrt; idex_mem_read = v.mr; exmem_branch = v.br; exmem_zero = v.z; dmem_busy = v.busy;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    cmp($sformatf("ctl[dut%0d]", e.sel), 16'(ctl_w[e.sel]), 16'(e.ctl));
    if (e.chk) begin
      cmp($sformatf("stall_cnt[dut%0d]", e.sel), sc_w[e.sel], e.sc);
      cmp($sformatf("flush_cnt[dut%0d]", e.sel), fc_w[e.sel], e.fc);
    end
    step++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl.push_back(rstv(0));
    tbl.push_back(idle(0, NRM, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8, 0, 1, 0, 8, 1, 0, 0, 0, BUB, 0, 0, 0));
    tbl.push_back(idle(0, NRM, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, NRM, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 5, 0, 1, 5, 1, 0, 0, 0, BUB, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3, 5, 1, 0, 5, 1, 0, 0, 0, NRM, 1, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, TKN, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, NRM, 1, 2, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 8, 0, 1, 0, 8, 1, 0, 0, 1, FRZ, 1, 2, 1));
    tbl.push_back(mk(0, 0, 8, 0, 1, 0, 8, 1, 0, 0, 0, BUB, 1, 2, 1));
    tbl.push_back(idle(0, NRM, 1, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, FRZ, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, TKN, 1, 3, 1));
    tbl.push_back(idle(0, NRM, 1, 3, 2));
    tbl.push_back(mk(0, 0, 8, 0, 1, 0, 8, 1, 1, 1, 0, TKN, 0, 0, 0));
    tbl.push_back(idle(0, NRM, 1, 3, 3));
    @(posedge clk);
    #1;
    foreach (tbl[i]) cyc(tbl[i]);
    // three-bubble load-use stall
    cyc(rstv(1));
    cyc(hz(1, BUB));
    cyc(idle(1, BUB));
    cyc(idle(1, BUB));
    cyc(idle(1, NRM, 1, 3, 0));
    // taken branch cancels the remaining bubble
    cyc(rstv(1));
    cyc(hz(1, BUB));
    cyc(idle(1, BUB));
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, TKN, 0, 0, 0));
    cyc(idle(1, NRM, 1, 2, 1));
    cyc(idle(1, NRM, 1, 2, 1));
    // reset in the middle of a stall
    cyc(hz(1, BUB));
    cyc(idle(1, BUB));
    cyc(rstv(1));
    cyc(idle(1, NRM, 1, 0, 0));
    cyc(idle(1, NRM, 1, 0, 0));
    // memory freeze during a stall resumes the remaining bubbles
    cyc(hz(1, BUB));
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 1, 1, 0));
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 1, 1, 0));
    cyc(idle(1, BUB, 1, 1, 0));
    cyc(idle(1, BUB));
    cyc(idle(1, NRM, 1, 3, 0));
    // 4-bit stall counter saturates
    cyc(rstv(2));
    for (int i = 0; i < 20; i++) begin
      cyc(hz(2, BUB));
      cyc(idle(2, NRM));
    end
    cyc(idle(2, NRM, 1, 15, 0));
    cyc(hz(2, BUB));
    cyc(idle(2, NRM, 1, 15, 0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
